// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop synchronized line, mid-bit sampling, 8N1 frames.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity check on parity_err.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            w_sample;
  logic            w_par_bad;

  // Sample point: half a bit into START, a full bit period in every later state.
  assign w_sample = (r_state == S_START) ? (r_cnt == HALF_LAST)
                                         : (r_state != S_IDLE) && (r_cnt == FULL_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_next = S_START;
      S_START: if (w_sample) w_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (w_sample && r_bit == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_sample) w_next = S_STOP;
`else
      S_DATA:  if (w_sample && r_bit == 3'd7) w_next = S_STOP;
`endif
      S_STOP:  if (w_sample) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_sample) ? '0 : r_cnt + CW'(1);
      if (r_state == S_START)
        r_bit <= '0;
      else if (r_state == S_DATA && w_sample)
        r_bit <= r_bit + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  // Even parity: the parity bit equals the XOR of the eight data bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (r_state == S_PARITY && w_sample)
        r_par_bad <= (r_rx_s != ^r_shift);
      if (r_state == S_STOP && w_sample)
        r_parity_err <= r_par_bad;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (r_state == S_DATA && w_sample)
        r_shift <= {r_rx_s, r_shift[7:1]};
      if (r_state == S_STOP && w_sample) begin
        frame_err <= !r_rx_s;
        if (r_rx_s && !w_par_bad) begin
          data  <= r_shift;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: table of single frames plus reset, back-to-back,
// glitch and mid-frame reset sequences.
module tb_uart_byte_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 2 + CPB / 2 + 10 * CPB;
  localparam int NBITS    = 11;
`else
  localparam int STOP_OFS = 2 + CPB / 2 + 9 * CPB;
  localparam int NBITS    = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0;
  int ferr_cyc = 0, perr_cyc = 0;
  int vq_cyc[$];
  int vq_data[$];

  always @(negedge clk) begin
    if (valid) begin
      n_valid = n_valid + 1;
      vq_cyc.push_back(cyc);
      vq_data.push_back(int'(data));
    end
    if (frame_err) begin
      n_ferr = n_ferr + 1;
      ferr_cyc = cyc;
    end
    if (parity_err) begin
      n_perr = n_perr + 1;
      perr_cyc = cyc;
    end
    if (busy) n_busy = n_busy + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                            output int e0);
    rx = 1'b0;
    e0 = cyc + 1;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    tick(CPB);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] byte_in;
    logic       stop_bit;
    logic       par_flip;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int e0, sv, sf, sp, sq, sb;

    vecs.push_back('{8'h49, 1'b1, 1'b0, 1, 0, 0, 8'h49});
    vecs.push_back('{8'h43, 1'b0, 1'b0, 0, 1, 0, 8'h49});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF});
    vecs.push_back('{8'hA5, 1'b0, 1'b0, 0, 1, 0, 8'hFF});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 1, 0, 0, 8'h5A});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h43, 1'b1, 1'b0, 1, 0, 0, 8'h43});
    vecs.push_back('{8'h43, 1'b1, 1'b1, 0, 0, 1, 8'h43});
    vecs.push_back('{8'h81, 1'b0, 1'b1, 0, 1, 1, 8'h43});
`endif

    // Reset held with the line toggling.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      tick(1);
    end
    check("rst_data",  int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ferr",  int'(frame_err), 0);
    check("rst_perr",  int'(parity_err), 0);
    check("rst_busy",  int'(busy), 0);
    rx  = 1'b1;
    rst = 1'b1;
    sb = n_busy;
    tick(200);
    check("idle_events", n_valid + n_ferr + n_perr, 0);
    check("idle_busy", n_busy - sb, 0);
    check("idle_data", int'(data), 0);

    // Single frames from the table, each followed by an idle gap.
    for (int k = 0; k < vecs.size(); k++) begin
      sv = n_valid; sf = n_ferr; sp = n_perr; sq = vq_cyc.size();
      send_frame(vecs[k].byte_in, vecs[k].stop_bit, vecs[k].par_flip, e0);
      tick(40);
      check($sformatf("v%0d_nvalid", k), n_valid - sv, vecs[k].exp_valid);
      check($sformatf("v%0d_nferr", k),  n_ferr - sf,  vecs[k].exp_ferr);
      check($sformatf("v%0d_nperr", k),  n_perr - sp,  vecs[k].exp_perr);
      check($sformatf("v%0d_data", k),   int'(data),   int'(vecs[k].exp_data));
      if (vecs[k].exp_valid == 1 && vq_cyc.size() > sq)
        check($sformatf("v%0d_valid_time", k), vq_cyc[sq] - e0, STOP_OFS);
      if (vecs[k].exp_ferr == 1 && n_ferr > sf)
        check($sformatf("v%0d_ferr_time", k), ferr_cyc - e0, STOP_OFS);
      if (vecs[k].exp_perr == 1 && n_perr > sp)
        check($sformatf("v%0d_perr_time", k), perr_cyc - e0, STOP_OFS);
      check($sformatf("v%0d_busy_after", k), int'(busy), 0);
    end

    // Back-to-back "INC" with no idle gap.
    begin
      int e0a, e0b, e0c;
      sv = n_valid; sf = n_ferr; sp = n_perr; sq = vq_cyc.size();
      send_frame(8'h49, 1'b1, 1'b0, e0a);
      send_frame(8'h4E, 1'b1, 1'b0, e0b);
      send_frame(8'h43, 1'b1, 1'b0, e0c);
      tick(40);
      check("b2b_nvalid", n_valid - sv, 3);
      check("b2b_errs", (n_ferr - sf) + (n_perr - sp), 0);
      if (vq_cyc.size() >= sq + 3) begin
        check("b2b_d0", vq_data[sq],     'h49);
        check("b2b_d1", vq_data[sq + 1], 'h4E);
        check("b2b_d2", vq_data[sq + 2], 'h43);
        check("b2b_t0", vq_cyc[sq] - e0a, STOP_OFS);
        check("b2b_gap1", vq_cyc[sq + 1] - vq_cyc[sq], NBITS * CPB);
        check("b2b_gap2", vq_cyc[sq + 2] - vq_cyc[sq + 1], NBITS * CPB);
      end
    end

    // Short low glitch on the line.
    sv = n_valid; sf = n_ferr; sb = n_busy;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("glitch_busy_seen", int'((n_busy - sb) > 0), 1);
    check("glitch_nvalid", n_valid - sv, 0);
    check("glitch_nferr", n_ferr - sf, 0);
    check("glitch_busy_after", int'(busy), 0);

    // Reset during data bit 4 of 0x44, then a clean 0x45.
    sv = n_valid; sf = n_ferr; sp = n_perr;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h44 >> i) & 8'h01) != 0;
      tick(CPB);
    end
    rx = 1'b0;
    tick(CPB / 2);
    rst = 1'b0;
    rx  = 1'b1;
    tick(2);
    rst = 1'b1;
    check("midrst_busy", int'(busy), 0);
    tick(40);
    check("midrst_strobes", (n_valid - sv) + (n_ferr - sf) + (n_perr - sp), 0);
    check("midrst_data", int'(data), 0);
    sq = vq_cyc.size();
    send_frame(8'h45, 1'b1, 1'b0, e0);
    tick(40);
    check("after_rst_nvalid", n_valid - sv, 1);
    check("after_rst_data", int'(data), 'h45);
    if (vq_cyc.size() > sq)
      check("after_rst_time", vq_cyc[sq] - e0, STOP_OFS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
